// File: rtl/hangman_game_ctrl_pkg.sv
// Shared hangman types: game state, letter-code range and the code-valid check.
// Latency: none (declarations only).
// Backpressure: none.
package hangman_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } state_e;

  localparam int unsigned LETTER_A = 1;   // code of 'A'
  localparam int unsigned LETTER_Z = 26;  // code of 'Z'
  localparam int unsigned ALPHA_N  = 26;  // guessed-letter bitmap size

  // Code 0 is a blank word position and codes above 'Z' are unused pad values;
  // neither is a legal guess.
  function automatic logic code_valid(input int unsigned code);
    return (code >= LETTER_A) && (code <= LETTER_Z);
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_if.sv
// Pad-side guess inputs, word load and game status outputs of the hangman core.
// Latency: none (wiring only).
// Backpressure: none; the core has no ready/stall path.
// master: drives word/guess inputs, reads status. slave: the game core.
interface hangman_game_ctrl_if #(
  parameter int WORD_LEN = 4,
  parameter int LETTER_W = 5,
  parameter int LIVES_W  = 3
);
  logic                         word_load_i;
  logic [WORD_LEN*LETTER_W-1:0] word_i;
  logic [LETTER_W-1:0]          guess_i;
  logic                         guess_btn_i;

  logic [WORD_LEN-1:0]          revealed_o;
  logic [LIVES_W-1:0]           lives_o;
  logic                         playing_o;
  logic                         won_o;
  logic                         lost_o;
  logic                         hit_o;
  logic                         miss_o;
  logic                         repeat_o;
  logic                         invalid_o;

  modport master (
    output word_load_i, word_i, guess_i, guess_btn_i,
    input  revealed_o, lives_o, playing_o, won_o, lost_o,
           hit_o, miss_o, repeat_o, invalid_o
  );

  modport slave (
    input  word_load_i, word_i, guess_i, guess_btn_i,
    output revealed_o, lives_o, playing_o, won_o, lost_o,
           hit_o, miss_o, repeat_o, invalid_o
  );

endinterface

// File: rtl/hangman_game_ctrl_input_sync.sv
// Two-flop synchroniser for the raw pad button and letter, plus rising-edge press detect.
// Latency: press/letter registered 2 edges after the first edge sampling the button high.
// Backpressure: none; clr_i drops any press already sampled on or before the clr_i edge.
// Ports: clk, rst_n, clr_i (drop in-flight press), btn_i/dat_i (async pad), dat_o/rise_o (aligned press).
module hangman_input_sync #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         btn_i,
  input  logic [W-1:0] dat_i,
  output logic [W-1:0] dat_o,
  output logic         rise_o
);

  logic         btn_meta_q;
  logic         btn_sync_q;
  logic         btn_prev_q;
  logic         clr_q;
  logic [W-1:0] dat_meta_q;
  logic [W-1:0] dat_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
      clr_q      <= 1'b0;
      dat_meta_q <= '0;
      dat_sync_q <= '0;
      dat_o      <= '0;
      rise_o     <= 1'b0;
    end else begin
      btn_meta_q <= btn_i;
      btn_sync_q <= btn_meta_q;
      dat_meta_q <= dat_i;
      dat_sync_q <= dat_meta_q;
      clr_q      <= clr_i;
      // Forcing the previous level high on the clear edge and the one after
      // hides any button level already inside the synchroniser, so a press
      // that started before (or with) the clear never appears afterwards.
      btn_prev_q <= (clr_i || clr_q) ? 1'b1 : btn_sync_q;
      rise_o     <= btn_sync_q && !btn_prev_q && !clr_i;
      // Letter travels with the button so it is aligned with rise_o.
      dat_o      <= dat_sync_q;
    end
  end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game core: secret word, revealed mask, lives, guessed-letter bitmap and game FSM.
// Latency: result pulse 3 edges after the first edge sampling the button; WON/LOST one edge later.
// Backpressure: none; presses outside PLAY are ignored, a load drops any in-flight press.
// Ports: wb_clk_i, wb_rst_ni (async active-low), bus (slave: word load, pad guess in; status, pulses out).
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int WORD_LEN  = 4,
  parameter int LETTER_W  = 5,
  parameter int MAX_LIVES = 6,
  parameter int LIVES_W   = $clog2(MAX_LIVES + 1)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  hangman_game_ctrl_if.slave bus
);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic                load;
  logic [LETTER_W-1:0] letter;
  logic                press_q;

  assign load = bus.word_load_i;

  hangman_input_sync #(
    .W (LETTER_W)
  ) u_input_sync (
    .clk    (wb_clk_i),
    .rst_n  (rst_n),
    .clr_i  (load),
    .btn_i  (bus.guess_btn_i),
    .dat_i  (bus.guess_i),
    .dat_o  (letter),
    .rise_o (press_q)
  );

  state_e                       state_q;
  state_e                       state_d;
  logic [WORD_LEN*LETTER_W-1:0] word_q;
  logic [WORD_LEN-1:0]          revealed_q;
  logic [LIVES_W-1:0]           lives_q;
  logic [ALPHA_N-1:0]           bitmap_q;
  logic                         hit_q;
  logic                         miss_q;
  logic                         repeat_q;
  logic                         invalid_q;
  logic                         playing;
  logic                         won;
  logic                         lost;

  // Guess decode and WORD_LEN parallel comparators.
  logic [ALPHA_N-1:0]  letter_oh;
  logic [WORD_LEN-1:0] match;
  logic [WORD_LEN-1:0] load_blank;
  logic                letter_ok;
  logic                seen;
  logic                all_rev;
  logic                no_lives;
  logic                eval;

  always_comb begin
    letter_oh = '0;
    for (int c = 0; c < ALPHA_N; c++) begin
      letter_oh[c] = (32'(letter) == 32'(c + 1));
    end
  end

  always_comb begin
    match      = '0;
    load_blank = '0;
    for (int p = 0; p < WORD_LEN; p++) begin
      // Blank positions are excluded so a code-0 guess can never reveal them.
      match[p]      = (word_q[p*LETTER_W +: LETTER_W] == letter) &&
                      (word_q[p*LETTER_W +: LETTER_W] != '0);
      load_blank[p] = (bus.word_i[p*LETTER_W +: LETTER_W] == '0);
    end
  end

  assign letter_ok = code_valid(32'(letter));
  assign seen      = |(letter_oh & bitmap_q);
  assign all_rev   = &revealed_q;
  assign no_lives  = (lives_q == '0);
  // A press is only scored while the game is genuinely live; on the edge that
  // latches WON/LOST, and on a load edge, it is discarded.
  assign eval      = press_q && !load && (state_q == PLAY) && !all_rev && !no_lives;

  // FSM: state register.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (all_rev)       state_d = WON;
          else if (no_lives) state_d = LOST;
        end
        default: ;
      endcase
    end
  end

  // FSM: outputs.
  always_comb begin
    playing = (state_q == PLAY);
    won     = (state_q == WON);
    lost    = (state_q == LOST);
  end

  // Game datapath.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      revealed_q <= '0;
      lives_q    <= '0;
      bitmap_q   <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      repeat_q   <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      repeat_q  <= 1'b0;
      invalid_q <= 1'b0;
      if (load) begin
        word_q     <= bus.word_i;
        revealed_q <= load_blank;
        lives_q    <= LIVES_W'(MAX_LIVES);
        bitmap_q   <= '0;
      end else if (eval) begin
        if (!letter_ok) begin
          invalid_q <= 1'b1;
        end else if (seen) begin
          repeat_q <= 1'b1;
        end else if (|match) begin
          bitmap_q   <= bitmap_q | letter_oh;
          revealed_q <= revealed_q | match;
          hit_q      <= 1'b1;
        end else begin
          bitmap_q <= bitmap_q | letter_oh;
          lives_q  <= no_lives ? '0 : lives_q - 1'b1;
          miss_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.revealed_o = revealed_q;
  assign bus.lives_o    = lives_q;
  assign bus.playing_o  = playing;
  assign bus.won_o      = won;
  assign bus.lost_o     = lost;
  assign bus.hit_o      = hit_q;
  assign bus.miss_o     = miss_q;
  assign bus.repeat_o   = repeat_q;
  assign bus.invalid_o  = invalid_q;

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Bench for hangman_game_ctrl: directed scenarios plus random presses/loads against a game model.
// Latency: model scores a press 3 edges after its first high sample.
// Backpressure: none.
module tb_hangman_game_ctrl;

  localparam int WL = 4;
  localparam int LW = 5;
  localparam int ML = 6;
  localparam int VW = $clog2(ML + 1);

  localparam logic [WL*LW-1:0] W_CAT = {5'd0, 5'd20, 5'd1, 5'd3};
  localparam logic [WL*LW-1:0] W_AAB = {5'd0, 5'd2, 5'd1, 5'd1};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hangman_game_ctrl_if #(.WORD_LEN(WL), .LETTER_W(LW), .LIVES_W(VW)) bus ();

  hangman_game_ctrl #(.WORD_LEN(WL), .LETTER_W(LW), .MAX_LIVES(ML)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  typedef struct {
    int k;
    int l;
  } press_t;

  press_t pq[$];
  int     mword[WL];
  bit     guessed[0:31];
  int     mstate;      // 0 idle, 1 playing, 2 won, 3 lost
  bit     m_hit, m_miss, m_rep, m_inv;
  bit     prev_btn;
  int     cyc;

  function automatic bit in_word(input int l);
    for (int p = 0; p < WL; p++) if (mword[p] == l) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [WL-1:0] m_revealed();
    logic [WL-1:0] r;
    for (int p = 0; p < WL; p++) r[p] = (mword[p] == 0) || guessed[mword[p]];
    return r;
  endfunction

  function automatic int m_lives();
    int misses = 0;
    for (int c = 1; c <= 26; c++) if (guessed[c] && !in_word(c)) misses++;
    return (misses >= ML) ? 0 : ML - misses;
  endfunction

  function automatic void model_reset();
    mstate = 0;
    for (int p = 0; p < WL; p++) mword[p] = 0;
    for (int c = 0; c < 32; c++) guessed[c] = 1'b0;
    pq.delete();
    prev_btn = 1'b0;
    {m_hit, m_miss, m_rep, m_inv} = 4'b0;
  endfunction

  function automatic void score(input int l);
    if (l < 1 || l > 26) m_inv = 1'b1;
    else if (guessed[l]) m_rep = 1'b1;
    else begin
      guessed[l] = 1'b1;
      if (in_word(l)) m_hit = 1'b1;
      else            m_miss = 1'b1;
    end
  endfunction

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      press_t pr;
      bit     ev;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        {m_hit, m_miss, m_rep, m_inv} = 4'b0;
        if (bus.word_load_i) begin
          for (int p = 0; p < WL; p++) mword[p] = int'(bus.word_i[p*LW +: LW]);
          for (int c = 0; c < 32; c++) guessed[c] = 1'b0;
          mstate = 1;
          pq.delete();
        end else begin
          ev = 1'b0;
          if (pq.size() > 0 && pq[0].k == cyc - 3) begin
            pr = pq.pop_front();
            ev = 1'b1;
          end
          if (mstate == 1) begin
            if (m_revealed() == '1)  mstate = 2;
            else if (m_lives() == 0) mstate = 3;
            else if (ev)             score(pr.l);
          end
          if (bus.guess_btn_i && !prev_btn) pq.push_back('{cyc, int'(bus.guess_i)});
        end
        prev_btn = bus.guess_btn_i;
      end
    end
  end

  function automatic logic [13:0] dut_vec();
    return {bus.revealed_o, bus.lives_o, bus.playing_o, bus.won_o, bus.lost_o,
            bus.hit_o, bus.miss_o, bus.repeat_o, bus.invalid_o};
  endfunction

  function automatic logic [13:0] exp_vec();
    if (mstate == 0) return '0;
    return {m_revealed(), VW'(m_lives()), mstate == 1, mstate == 2, mstate == 3,
            m_hit, m_miss, m_rep, m_inv};
  endfunction

  // Per-cycle comparison against the model and result-pulse counter.
  initial forever begin
    @(negedge clk);
    check("outputs_vs_model", 32'(dut_vec()), 32'(exp_vec()));
    if (bus.hit_o || bus.miss_o || bus.repeat_o || bus.invalid_o) pulse_cnt++;
  end

  // ---------------- stimulus helpers (called #1 after a rising edge) ----------------
  task automatic load(input logic [WL*LW-1:0] w);
    bus.word_i      = w;
    bus.word_load_i = 1'b1;
    @(posedge clk); #1;
    bus.word_load_i = 1'b0;
  endtask

  task automatic drive_press(input logic [LW-1:0] l, input int hold, input int gap);
    bus.guess_i     = l;
    bus.guess_btn_i = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.guess_btn_i = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [LW-1:0] l);
    drive_press(l, 2, 6);
  endtask

  logic [WL*LW-1:0] cur_word;

  initial begin
    bus.word_load_i = 1'b0;
    bus.word_i      = '0;
    bus.guess_i     = '0;
    bus.guess_btn_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_vec()), 32'(14'h0));

    // Load C,A,T,blank then guess A with explicit latency checks.
    load(W_CAT);
    check("load_revealed", 32'(bus.revealed_o), 32'(4'b1000));
    check("load_lives", 32'(bus.lives_o), 32'd6);
    check("load_playing", 32'(bus.playing_o), 32'd1);
    bus.guess_i = 5'd1;
    bus.guess_btn_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("hit_not_before_k3", 32'(bus.hit_o), 32'd0);
    @(posedge clk);
    #1 check("hit_at_k3", 32'(bus.hit_o), 32'd1);
    check("reveal_A", 32'(bus.revealed_o), 32'(4'b1010));
    bus.guess_btn_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Finish the word, then a press after the win does nothing.
    press(5'd3);
    press(5'd20);
    check("won_flag", 32'(bus.won_o), 32'd1);
    check("won_not_playing", 32'(bus.playing_o), 32'd0);
    pulse_cnt = 0;
    press(5'd17);
    check("no_pulse_after_win", 32'(pulse_cnt), 32'd0);
    check("lives_after_win", 32'(bus.lives_o), 32'd6);

    // Miss then repeat, then a game lost by six distinct misses.
    load(W_CAT);
    press(5'd17);
    press(5'd17);
    check("lives_after_repeat", 32'(bus.lives_o), 32'd5);
    load(W_CAT);
    for (int c = 4; c <= 9; c++) press(LW'(c));
    check("lost_flag", 32'(bus.lost_o), 32'd1);
    check("lost_lives", 32'(bus.lives_o), 32'd0);

    // Invalid codes, then a long hold counts once.
    load(W_CAT);
    press(5'd0);
    press(5'd27);
    check("invalid_lives", 32'(bus.lives_o), 32'd6);
    check("invalid_revealed", 32'(bus.revealed_o), 32'(4'b1000));
    pulse_cnt = 0;
    drive_press(5'd1, 100, 6);
    check("held_one_pulse", 32'(pulse_cnt), 32'd1);

    // Duplicate letters reveal together; load with a simultaneous press.
    load(W_AAB);
    press(5'd1);
    check("dup_reveal", 32'(bus.revealed_o), 32'(4'b1011));
    pulse_cnt = 0;
    bus.word_i      = W_AAB;
    bus.word_load_i = 1'b1;
    bus.guess_i     = 5'd17;
    bus.guess_btn_i = 1'b1;
    @(posedge clk);
    #1 bus.word_load_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.guess_btn_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("load_press_no_pulse", 32'(pulse_cnt), 32'd0);
    check("load_press_lives", 32'(bus.lives_o), 32'd6);
    check("load_press_fresh", 32'(bus.revealed_o), 32'(4'b1000));

    // Asynchronous reset in the middle of a game.
    load(W_CAT);
    press(5'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(dut_vec()), 32'(14'h0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Random presses and loads, checked cycle by cycle by the model.
    cur_word = W_CAT;
    load(cur_word);
    for (int i = 0; i < 80; i++) begin
      int unsigned r;
      int          pos;
      logic [LW-1:0] l;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        for (int p = 0; p < WL; p++)
          cur_word[p*LW +: LW] = ($urandom_range(0, 3) == 0) ? LW'(0) : LW'($urandom_range(1, 8));
        load(cur_word);
      end else begin
        if (r < 7) begin
          pos = int'($urandom_range(0, WL - 1));
          l = cur_word[pos*LW +: LW];
        end else begin
          l = LW'($urandom_range(0, 31));
        end
        drive_press(l, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      end
    end
    repeat (8) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
